// File: rtl/lcd_feeder_pkg.sv
// Shared types and constants for the LCD text feeder: FSM state encoding,
// DDRAM "set address" command bytes and frame geometry.
package lcd_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR1 = 3'd1,
        S_LINE1 = 3'd2,
        S_ADDR2 = 3'd3,
        S_LINE2 = 3'd4
    } feeder_state_t;

    localparam logic [7:0] DDRAM_LINE1 = 8'h80;
    localparam logic [7:0] DDRAM_LINE2 = 8'hC0;
    localparam int         LINE_LEN    = 16;
    localparam int         FRAME_ITEMS = 34;

endpackage

// File: rtl/lcd_refresh_timer.sv
// Free-running auto-refresh timer: o_tick is high for one cycle every PERIOD
// cycles. The count restarts on reset and on every wrap.
module lcd_refresh_timer #(
    parameter int PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(PERIOD - 1));

    // Count up to PERIOD-1, then wrap to zero.
    always_ff @(posedge clk) begin
        if (rst || o_tick) r_cnt <= '0;
        else               r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/lcd_text_feeder.sv
// 2x16 character frame buffer that streams full redraws to the text LCD
// driver as command/data items over a valid/ready handshake.
// Optional macro LCD_FEEDER_AUTO_REFRESH_EN adds a periodic redraw every
// REFRESH_CYCLES clocks; without it redraws come only from reset, writes and
// refresh_req.
module lcd_text_feeder
    import lcd_feeder_pkg::*;
#(
    parameter logic [7:0] CLEAR_CHAR     = 8'h20,
    parameter int         REFRESH_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh_req,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    output logic       busy,
    output logic       frame_done
);

    logic [7:0]    r_buf [32];
    logic          r_dirty;
    feeder_state_t r_state, w_state_n;
    logic [3:0]    r_idx, w_idx_n;
    logic          r_valid, w_valid_n;
    logic          r_rs, w_rs_n;
    logic [7:0]    r_data, w_data_n;
    logic          r_done, w_done_n;
    logic          w_tick;
    logic          w_xfer;
    logic          w_start;
    logic [3:0]    w_idx_inc;
    logic          w_last;

`ifdef LCD_FEEDER_AUTO_REFRESH_EN
    lcd_refresh_timer #(
        .PERIOD (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );
`else
    localparam int unused_refresh_cycles = REFRESH_CYCLES;
    assign w_tick = 1'b0;
`endif

    assign w_xfer    = r_valid && cmd_ready;
    assign w_start   = (r_state == S_IDLE) && r_dirty;
    assign w_idx_inc = r_idx + 4'd1;
    assign w_last    = (r_idx == 4'(LINE_LEN - 1));

    assign cmd_valid  = r_valid;
    assign cmd_rs     = r_rs;
    assign cmd_data   = r_data;
    assign frame_done = r_done;
    assign busy       = (r_state != S_IDLE);

    // Frame buffer: cleared to CLEAR_CHAR on reset, user writes land at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= CLEAR_CHAR;
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Redraw request flag; any new request beats the clear on frame start.
    always_ff @(posedge clk) begin
        if (rst)                              r_dirty <= 1'b1;
        else if (wr_en || refresh_req || w_tick) r_dirty <= 1'b1;
        else if (w_start)                     r_dirty <= 1'b0;
    end

    // FSM state and registered output item.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_valid <= w_valid_n;
            r_rs    <= w_rs_n;
            r_data  <= w_data_n;
            r_done  <= w_done_n;
        end
    end

    // Next state and next output item; output holds unless a transfer occurs.
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_valid_n = r_valid;
        w_rs_n    = r_rs;
        w_data_n  = r_data;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_dirty) begin
                    w_state_n = S_ADDR1;
                    w_valid_n = 1'b1;
                    w_rs_n    = 1'b0;
                    w_data_n  = DDRAM_LINE1;
                end
            end
            S_ADDR1: begin
                if (w_xfer) begin
                    w_state_n = S_LINE1;
                    w_idx_n   = '0;
                    w_rs_n    = 1'b1;
                    w_data_n  = r_buf[0];
                end
            end
            S_LINE1: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_idx_n  = w_idx_inc;
                        w_data_n = r_buf[{1'b0, w_idx_inc}];
                    end else begin
                        w_state_n = S_ADDR2;
                        w_rs_n    = 1'b0;
                        w_data_n  = DDRAM_LINE2;
                    end
                end
            end
            S_ADDR2: begin
                if (w_xfer) begin
                    w_state_n = S_LINE2;
                    w_idx_n   = '0;
                    w_rs_n    = 1'b1;
                    w_data_n  = r_buf[16];
                end
            end
            S_LINE2: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_idx_n  = w_idx_inc;
                        w_data_n = r_buf[{1'b1, w_idx_inc}];
                    end else begin
                        w_state_n = S_IDLE;
                        w_valid_n = 1'b0;
                        w_done_n  = 1'b1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

endmodule
